// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the SD sector-channel drive arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import sd_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int unsigned j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j[IW-1:0]]) begin
                any = 1'b1;
                idx = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/sd_drive_arbiter.sv
// Round-robin multiplexer of per-drive sector requests onto one user_io SD channel,
// with buffer steering, sticky mount-change flags and a no-ack timeout.
module sd_drive_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NUM_DRIVES = 4,
    parameter int LBA_W      = 32,
    parameter int TIMEOUT_W  = 24,
    localparam int GW        = idx_w(NUM_DRIVES)
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic [NUM_DRIVES-1:0]       drv_rd,
    input  logic [NUM_DRIVES-1:0]       drv_wr,
    input  logic [NUM_DRIVES*LBA_W-1:0] drv_lba,
    output logic [NUM_DRIVES-1:0]       drv_done,
    output logic                        drv_err,
    output logic [NUM_DRIVES-1:0]       drv_buff_wr,
    input  logic [NUM_DRIVES*8-1:0]     drv_buff_din,
    output logic [NUM_DRIVES-1:0]       drv_changed,
    input  logic [NUM_DRIVES-1:0]       drv_changed_clr,
    input  logic [NUM_DRIVES-1:0]       img_mounted,
    output logic [LBA_W-1:0]            sd_lba,
    output logic                        sd_rd,
    output logic                        sd_wr,
    input  logic                        sd_ack,
    input  logic                        sd_buff_wr,
    output logic [7:0]                  sd_buff_din,
    output logic                        busy,
    output logic [GW-1:0]               grant
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}} - 1'b1;
    localparam logic [GW-1:0]        LAST_DRV = GW'(NUM_DRIVES - 1);

    arb_state_t             state, state_d;
    logic [GW-1:0]          rr_ptr, pick;
    logic                   any_req, timed_out, ack_q, err_q;
    logic [TIMEOUT_W-1:0]   tmo_cnt;
    logic [NUM_DRIVES-1:0]  pending;

    assign pending = drv_rd | drv_wr;

    rr_arbiter #(.N(NUM_DRIVES), .IW(GW)) u_rr (
        .req (pending),
        .ptr (rr_ptr),
        .any (any_req),
        .idx (pick)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Timeout fires on the cycle the counter would reach all-ones, so sd_rd/sd_wr
    // stays up for exactly 2^TIMEOUT_W-1 cycles without an ack.
    always_comb begin
        state_d   = state;
        timed_out = 1'b0;
        case (state)
            ST_IDLE: if (any_req) state_d = ST_REQ;
            ST_REQ: begin
                if (sd_ack) begin
                    state_d = ST_XFER;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d   = ST_DONE;
                    timed_out = 1'b1;
                end
            end
            ST_XFER: if (ack_q && !sd_ack) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            sd_lba  <= '0;
            grant   <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= sd_ack;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant   <= pick;
                        sd_lba  <= drv_lba[pick*LBA_W +: LBA_W];
                        sd_wr   <= drv_wr[pick];
                        sd_rd   <= ~drv_wr[pick];
                        tmo_cnt <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (sd_ack || timed_out) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        err_q <= timed_out;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: rr_ptr <= (grant == LAST_DRV) ? '0 : grant + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) drv_changed <= '0;
        else       drv_changed <= (drv_changed & ~drv_changed_clr) | img_mounted;
    end

    assign busy        = (state != ST_IDLE);
    assign sd_buff_din = drv_buff_din[grant*8 +: 8];

    always_comb begin
        drv_buff_wr = '0;
        drv_done    = '0;
        drv_err     = 1'b0;
        if (state == ST_XFER) drv_buff_wr[grant] = sd_buff_wr;
        if (state == ST_DONE) begin
            drv_done[grant] = 1'b1;
            drv_err         = err_q;
        end
    end

endmodule

// File: doc/sd_drive_arbiter.md
Name: sd_drive_arbiter

Overview:
Multiplexes N virtual floppy/hard-disk requesters onto the single user_io SD sector channel (sd_lba/sd_rd/sd_wr/sd_ack plus the 512-byte buffer port). This generalises the current single-image hookup to multi-drive configurations. Arbitration is round-robin, one sector transaction at a time. The buffer write strobe and buffer read data are steered to and from the granted drive. Per-drive mount-change flags and a no-ack timeout are maintained.

Parameters:
NUM_DRIVES, 4, number of drive requesters (1..8)
LBA_W, 32, sector address width
TIMEOUT_W, 24, width of the no-ack timeout counter; timeout fires at 2^TIMEOUT_W-1 cycles

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
drv_rd  in  NUM_DRIVES  per-drive read request, level, held until drv_done
drv_wr  in  NUM_DRIVES  per-drive write request, level, held until drv_done
drv_lba  in  NUM_DRIVES*LBA_W  per-drive sector address, drive i at [i*LBA_W +: LBA_W]
drv_done  out  NUM_DRIVES  one-cycle completion pulse to the granted drive
drv_err  out  1  valid with drv_done; 1 = timeout
drv_buff_wr  out  NUM_DRIVES  sd_buff_wr steered to the granted drive only
drv_buff_din  in  NUM_DRIVES*8  per-drive buffer data for writes
drv_changed  out  NUM_DRIVES  sticky mount-change flag
drv_changed_clr  in  NUM_DRIVES  clears the corresponding drv_changed bit
img_mounted  in  NUM_DRIVES  mount pulse per image slot from user_io
sd_lba  out  LBA_W  to user_io
sd_rd  out  1  to user_io
sd_wr  out  1  to user_io
sd_ack  in  1  from user_io
sd_buff_wr  in  1  buffer byte strobe from user_io
sd_buff_din  out  8  mux of drv_buff_din for the granted drive
busy  out  1  high when state is not IDLE
grant  out  $clog2(NUM_DRIVES) (min 1)  index of the granted drive, valid while busy

Behaviour:
- Reset (synchronous, overrides all): state IDLE; sd_rd=sd_wr=0; sd_lba=0; drv_done=0; drv_err=0; drv_changed=0; rr pointer=0; timeout counter=0; grant=0. A reset mid-transaction drops sd_rd/sd_wr on the next edge and emits no drv_done.
- Requester i is pending when drv_rd[i]|drv_wr[i].
- IDLE: if any drive is pending, grant the first pending index at or after the rr pointer, with wrap-around. Latch grant, sd_lba<=drv_lba[grant], and the op: wr wins if rd and wr are both high. Assert sd_rd or sd_wr from the next cycle. Go to REQ. Grant to request assertion is 1 cycle.
- REQ: hold sd_rd/sd_wr and count cycles.
  - If sd_ack=1: deassert sd_rd/sd_wr, go to XFER.
  - If the counter saturates: deassert, go to DONE with err=1.
- XFER: sd_buff_wr is passed combinationally to drv_buff_wr[grant]; all other bits are 0. sd_buff_din=drv_buff_din[grant] combinationally. On sd_ack falling (registered compare) go to DONE with err=0.
- DONE (one cycle): drv_done[grant]=1; drv_err=err. rr pointer<=grant+1 mod NUM_DRIVES. Next state IDLE. A new grant is possible on the following cycle, so minimum spacing between transactions is 2 idle cycles.
- Requests deasserted while in REQ/XFER are ignored; the transaction completes.
- drv_changed[i]: set by img_mounted[i]. If set and clear arrive in the same cycle, set wins. Mount pulses do not abort an in-flight transaction.
- sd_lba is stable from grant until leaving DONE.

Decomposition:
- Package sd_arb_pkg: state enum {ST_IDLE, ST_REQ, ST_XFER, ST_DONE}; function idx_w(n) returning max(1,$clog2(n)).
- Sub-module rr_arbiter: parameter N; inputs req[N] and ptr; outputs any and idx. Purely combinational priority rotate. The top holds the FSM, timeout counter, steering and sticky flags.

Test Plan:
- Single read, NUM_DRIVES=4: drv_rd[0]=1, lba=0x10 -> sd_rd=1 with sd_lba=0x10 on the cycle after grant; ack high 600 cycles with 512 sd_buff_wr -> drv_buff_wr[0] sees all 512 strobes, others see 0; drv_done[0] pulses once; drv_err=0.
- Contention: drv_rd[1] and drv_wr[2] together, rr=0 -> drive 1 read served first, then drive 2 write with sd_wr=1. Re-raise drive 1 while drive 3 pends after drive 2 -> drive 3 before drive 1.
- Write data steering: drv_buff_din[2]=0xA5, others 0x00, grant=2 -> sd_buff_din=0xA5 throughout XFER.
- Timeout, TIMEOUT_W=4: sd_ack held 0 -> sd_rd drops after 15 cycles; drv_done pulses with drv_err=1; next pending drive is granted.
- Mount flags: img_mounted[3] pulse -> drv_changed[3]=1 and it persists. Simultaneous drv_changed_clr[3] and img_mounted[3] -> stays 1. Clear alone -> 0.
- Reset mid-XFER: reset asserted -> next edge sd_rd=sd_wr=0, busy=0, no drv_done, drv_changed=0.
